mdio_master_ctrl: RTL and testbench
===================================

# mdio_master_ctrl

Clause-22 MDIO management master for the Ethernet MAC path of the CHERIoT subsystem. Accepts single register read/write requests over a valid/ready port, serialises them onto MDC/MDIO toward the external PHY, and returns read data on a one-cycle response strobe. It is the initiator side of the PHY-register responder used in the FPGA-level bench, and sits between the Ethernet CSR block and the `eth_mdc`/`eth_mdio` pads.

## Interface
- `ClkDiv`, default 20: MDC half-period in `clk_i` cycles; legal range ≥2.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when `req_valid_i & req_ready_o`.
- `req_write_i`  in  1  1 = write (OP 01), 0 = read (OP 10).
- `req_phy_addr_i`  in  5  PHY address.
- `req_reg_addr_i`  in  5  register address.
- `req_wdata_i`  in  16  write data.
- `rsp_valid_o`  out  1  one-cycle completion pulse, reads and writes.
- `rsp_rdata_o`  out  16  read data; 0 after a write; held until the next completion.
- `busy_o`  out  1  frame in progress.
- `mdc_o`  out  1  management clock.
- `mdio_o`, `mdio_oe_o`  out  1 each  pad data and output enable.
- `mdio_i`  in  1  pad input.

## Operation
- Frame bits n = 0..63, MSB first: preamble 32×1 (n 0–31), ST 01 (32–33), OP (34–35), PHYAD (36–40), REGAD (41–45), TA (46–47), DATA (48–63).
- FSM: IDLE → PREAMBLE → HEADER → TURNAROUND → DATA → DONE → IDLE.
- IDLE: `req_ready_o`=1, `mdc_o`=0, `mdio_o`=1, `mdio_oe_o`=0. A handshake latches all request fields; the next cycle enters PREAMBLE.
- Write: `mdio_oe_o`=1 for n 0–63; TA driven as 1,0; DATA = `req_wdata_i[15:0]`.
- Read: `mdio_oe_o`=1 for n 0–45 and 0 for n 46–63. `mdio_i` is shifted into the read register MSB first at the MDC rising edge of n 48–63.
- DONE: lasts one cycle.
  - `rsp_valid_o`=1.
  - `rsp_rdata_o` is updated to the read value, or to 0 for a write.
  - `mdio_oe_o`=0 and `mdio_o`=1.
- `req_valid_i` while not in IDLE is ignored (`req_ready_o`=0); the requester holds its request.
- `rst_i` mid-frame aborts the frame immediately, with no response pulse. Every output returns to its reset value.

## Timing
- Reset values: `req_ready_o`=1, `rsp_valid_o`=0, `rsp_rdata_o`=0, `busy_o`=0, `mdc_o`=0, `mdio_o`=1, `mdio_oe_o`=0.
- Each bit is one MDC period of 2×`ClkDiv` cycles: a low phase followed by a high phase.
  - `mdio_o` and `mdio_oe_o` change only in the cycle `mdc_o` falls, or in the first cycle of the frame.
  - Read sampling occurs in the cycle `mdc_o` rises.
- Handshake in cycle T:
  - `busy_o`=1 and bit 0 is driven from T+1.
  - `rsp_valid_o`=1 in cycle T+1+64×2×`ClkDiv`.
  - `req_ready_o`=1 again from the following cycle.
- Back-to-back requests: the minimum gap between frames is 2 cycles (DONE plus IDLE).
- MDC toggles only while `busy_o`=1. The divider restarts at 0 for every frame.

## Configuration
- `MDIO_PRE_SUPPRESS_EN`
  - Defined: the 32-bit preamble is sent only on the first frame after reset. Later frames start directly at ST (n=32), and the completion latency drops by 32×2×`ClkDiv`.
  - Undefined: every frame carries the full preamble. The suppression flag and its logic are absent.

## Structure
- Package `mdio_pkg` holds:
  - state enum `mdio_state_e`;
  - OP codes `MdioOpWrite`=2'b01 and `MdioOpRead`=2'b10;
  - frame constants (`MdioPreLen`=32, `MdioFrameLen`=64, TA and DATA bit offsets).
- Sub-module `mdio_clk_gen` holds the `ClkDiv` counter, `mdc_o`, and the one-cycle `rise_tick`/`fall_tick` strobes. It is enabled by `busy_o` and cleared in IDLE.

## Test plan
- Write PHY 1, reg 0x04, data 0xA5C3 with `ClkDiv`=2. MDIO sequence must be 32×1, 01, 01, 00001, 00100, 10, 1010010111000011. `rsp_valid_o` must pulse at T+257 with `rsp_rdata_o`=0.
- Read PHY 3, reg 0x02, with the bench responder driving 0x1234. `mdio_oe_o` must drop at n=46 and `rsp_rdata_o` must be 0x1234. A responder register-write cross-check must read back the prior written value.
- `req_valid_i` held through a busy frame must be accepted exactly once, in the cycle after DONE. A second `rsp_valid_o` must follow 258 cycles later.
- `rst_i` at frame bit 40:
  - outputs return to reset values within the same cycle;
  - no `rsp_valid_o`;
  - the next request completes normally.
- `ClkDiv`=20: `mdc_o` period is 40 cycles, and `mdio_o` transitions never coincide with a rising MDC edge.
- With `MDIO_PRE_SUPPRESS_EN`: the second frame shows no preamble and completes 128 cycles earlier (`ClkDiv`=2).

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the clause-22 MDIO master.
package mdio_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StHeader,
    StTurnaround,
    StData,
    StDone
  } mdio_state_e;

  localparam logic [1:0]  MdioOpWrite  = 2'b01;
  localparam logic [1:0]  MdioOpRead   = 2'b10;
  localparam logic [1:0]  MdioSt       = 2'b01;
  localparam logic [1:0]  MdioTaWr     = 2'b10;
  localparam logic [31:0] MdioPreamble = 32'hFFFF_FFFF;

  localparam int MdioPreLen   = 32;
  localparam int MdioFrameLen = 64;
  localparam int MdioTaBit    = 46;
  localparam int MdioDataBit  = 48;

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: low phase then high phase of ClkDiv cycles each, held at 0 while disabled.
module mdio_clk_gen #(
  parameter int ClkDiv = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic mdc_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);
  localparam int CntW = $clog2(2 * ClkDiv);
  localparam logic [CntW-1:0] HalfCnt = CntW'(ClkDiv);
  localparam logic [CntW-1:0] LastCnt = CntW'(2 * ClkDiv - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mdc_q;

  assign cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= (cnt_d >= HalfCnt);
    end
  end

  assign mdc_o       = mdc_q;
  // rise_tick marks the first high cycle; fall_tick the last cycle of a bit, MDC falls after it.
  assign rise_tick_o = en_i & (cnt_q == HalfCnt);
  assign fall_tick_o = en_i & (cnt_q == LastCnt);

endmodule

// File: rtl/mdio_master_ctrl.sv
// Clause-22 MDIO master: one read/write request per frame, completion pulse with read data.
// Optional MDIO_PRE_SUPPRESS_EN: only the first frame after reset carries the preamble.
module mdio_master_ctrl
  import mdio_pkg::*;
#(
  parameter int ClkDiv = 20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [4:0]  req_phy_addr_i,
  input  logic [4:0]  req_reg_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i
);
  mdio_state_e state_q, state_d;
  logic [5:0]  bit_q, bit_d;
  logic        write_q;
  logic [4:0]  phy_q, reg_q;
  logic [15:0] wdata_q, rd_q, rdata_q;
  logic        mdc_en, rise_tick, fall_tick;
  logic [MdioFrameLen-1:0] frame;

  assign mdc_en = state_q inside {StPreamble, StHeader, StTurnaround, StData};

  mdio_clk_gen #(.ClkDiv(ClkDiv)) u_clk_gen (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (mdc_en),
    .mdc_o       (mdc_o),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  assign frame = {MdioPreamble, MdioSt, write_q ? MdioOpWrite : MdioOpRead,
                  phy_q, reg_q, MdioTaWr, wdata_q};

`ifdef MDIO_PRE_SUPPRESS_EN
  logic pre_sent_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   pre_sent_q <= 1'b0;
    else if (state_q == StHeader) pre_sent_q <= 1'b1;
  end
`endif

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    mdio_o      = 1'b1;
    mdio_oe_o   = 1'b0;
    case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_d = StPreamble;
          bit_d   = '0;
`ifdef MDIO_PRE_SUPPRESS_EN
          if (pre_sent_q) begin
            state_d = StHeader;
            bit_d   = 6'(MdioPreLen);
          end
`endif
        end
      end
      StDone: begin
        rsp_valid_o = 1'b1;
        state_d     = StIdle;
      end
      default: begin
        // Reads release the line from the turnaround onward.
        mdio_oe_o = write_q | (bit_q < 6'(MdioTaBit));
        if (mdio_oe_o) mdio_o = frame[6'(MdioFrameLen - 1) - bit_q];
        if (fall_tick) begin
          bit_d = bit_q + 6'd1;
          if (bit_q == 6'(MdioFrameLen - 1))     state_d = StDone;
          else if (bit_q == 6'(MdioDataBit - 1)) state_d = StData;
          else if (bit_q == 6'(MdioTaBit - 1))   state_d = StTurnaround;
          else if (bit_q == 6'(MdioPreLen - 1))  state_d = StHeader;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      bit_q   <= '0;
      write_q <= 1'b0;
      phy_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      if (state_q == StIdle && req_valid_i) begin
        write_q <= req_write_i;
        phy_q   <= req_phy_addr_i;
        reg_q   <= req_reg_addr_i;
        wdata_q <= req_wdata_i;
      end
      if (rise_tick && state_q == StData) rd_q <= {rd_q[14:0], mdio_i};
      // Load on entry to DONE so the data is valid alongside the response pulse.
      if (state_q == StData && state_d == StDone) rdata_q <= write_q ? 16'h0 : rd_q;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Directed bench for mdio_master_ctrl with a behavioural clause-22 PHY register responder.
module tb_mdio_master_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [4:0]  req_phy = '0, req_reg = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, rsp_valid, busy, mdc, mdio_o, mdio_oe;
  logic        mdio_i = 1'b1;
  logic [15:0] rsp_rdata;

  logic        v20 = 1'b0;
  logic        rdy20, rsp20, busy20, mdc20, mo20, oe20;
  logic [15:0] rd20;

  mdio_master_ctrl #(.ClkDiv(2)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_phy_addr_i(req_phy), .req_reg_addr_i(req_reg),
    .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .busy_o(busy), .mdc_o(mdc), .mdio_o(mdio_o), .mdio_oe_o(mdio_oe), .mdio_i(mdio_i)
  );

  mdio_master_ctrl #(.ClkDiv(20)) dut20 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v20), .req_ready_o(rdy20),
    .req_write_i(1'b1), .req_phy_addr_i(5'd7), .req_reg_addr_i(5'd9),
    .req_wdata_i(16'h5A5A), .rsp_valid_o(rsp20), .rsp_rdata_o(rd20),
    .busy_o(busy20), .mdc_o(mdc20), .mdio_o(mo20), .mdio_oe_o(oe20), .mdio_i(1'b1)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Completion latency in cycles after the handshake, ClkDiv=2 (64 bits x 4 cycles + 1).
  function automatic int exp_lat(input bit first);
`ifdef MDIO_PRE_SUPPRESS_EN
    return first ? 257 : 129;
`else
    return 257;
`endif
  endfunction

  // PHY responder: decodes the header on MDC rising edges, serves reads, stores writes.
  logic [15:0] regs [32];
  logic [63:0] cap, oe_cap;
  logic [12:0] hdr;
  logic [15:0] wsr;
  logic [4:0]  ra;
  bit          rd_op, mdc_prev, mo_prev;
  int          pos = -1, ncap = 0, viol = 0;

  always @(posedge clk) begin
    if (rst) begin
      pos = -1; mdio_i = 1'b1; mdc_prev = 1'b0; mo_prev = 1'b1;
    end else begin
      if (!busy) begin
        pos = -1; mdio_i = 1'b1; cap = '0; oe_cap = '0; ncap = 0;
      end else if (mdc && !mdc_prev) begin
        cap = {cap[62:0], mdio_o}; oe_cap = {oe_cap[62:0], mdio_oe}; ncap++;
        if (pos < 0) begin
          if (mdio_oe && !mdio_o) pos = 32;
        end else pos++;
        if (pos >= 33 && pos <= 45) hdr = {hdr[11:0], mdio_o};
        if (pos == 45) begin rd_op = (hdr[11:10] == 2'b10); ra = hdr[4:0]; end
        if (!rd_op && pos >= 48) wsr = {wsr[14:0], mdio_o};
        if (!rd_op && pos == 63) regs[ra] = wsr;
        if (rd_op && pos >= 47 && pos <= 62) mdio_i = regs[ra][62 - pos];
        else if (pos == 63) mdio_i = 1'b1;
      end
      if (mdc && !mdc_prev && mdio_o !== mo_prev) viol++;
      mdc_prev = mdc; mo_prev = mdio_o;
    end
  end

  // ClkDiv=20 monitor: MDC rise-to-rise spacing and MDIO stability at rising edges.
  int  cyc20 = 0, last_rise = -1, nper20 = 0, bad20 = 0, viol20 = 0;
  bit  mdc20_prev, mo20_prev;
  always @(posedge clk) begin
    cyc20++;
    if (!busy20) last_rise = -1;
    else if (mdc20 && !mdc20_prev) begin
      if (last_rise >= 0) begin
        nper20++;
        if (cyc20 - last_rise != 40) bad20++;
      end
      last_rise = cyc20;
      if (mo20 !== mo20_prev) viol20++;
    end
    mdc20_prev = mdc20; mo20_prev = mo20;
  end

  task automatic send(input logic w, input logic [4:0] pa, input logic [4:0] rg,
                      input logic [15:0] wd, output int lat);
    int guard = 0;
    @(negedge clk);
    req_write = w; req_phy = pa; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready && guard < 1000) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20000) begin @(negedge clk); lat++; end
  endtask

  initial begin
    int lat, c, hs, t_rsp1, t_hs2, t_rsp2, nrsp, b40;
    bit drop;
    for (int i = 0; i < 32; i++) regs[i] = 16'h0;
    regs[2] = 16'h1234;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {req_ready, rsp_valid, rsp_rdata, busy, mdc, mdio_o, mdio_oe},
        {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0});
    rst = 1'b0;

    // Write PHY 1 reg 4: 32x1 | 01 | 01 | 00001 | 00100 | 10 | A5C3 -> 0x5092 header word
    send(1'b1, 5'd1, 5'd4, 16'hA5C3, lat);
    chk("wr_latency", 64'(lat), 64'(exp_lat(1)));
    chk("wr_frame", cap, 64'hFFFF_FFFF_5092_A5C3);
    chk("wr_nbits", 64'(ncap), 64'd64);
    chk("wr_rdata", 64'(rsp_rdata), 64'h0);
    @(negedge clk);
    chk("rsp_one_cycle", {63'd0, rsp_valid}, 64'd0);
    chk("ready_after_done", {63'd0, req_ready}, 64'd1);

    // Read PHY 3 reg 2: line released from n=46
    send(1'b0, 5'd3, 5'd2, 16'h0, lat);
    chk("rd_latency", 64'(lat), 64'(exp_lat(0)));
    chk("rd_rdata", 64'(rsp_rdata), 64'h1234);
`ifdef MDIO_PRE_SUPPRESS_EN
    chk("rd_oe_profile", oe_cap, 64'h0000_0000_FFFC_0000);
    chk("rd_nbits", 64'(ncap), 64'd32);
`else
    chk("rd_oe_profile", oe_cap, 64'hFFFF_FFFF_FFFC_0000);
    chk("rd_nbits", 64'(ncap), 64'd64);
`endif

    // Read back the register written earlier
    send(1'b0, 5'd1, 5'd4, 16'h0, lat);
    chk("xcheck_rdata", 64'(rsp_rdata), 64'hA5C3);

    // Request held through a busy frame
    @(negedge clk);
    req_write = 1'b0; req_phy = 5'd3; req_reg = 5'd2; req_valid = 1'b1;
    c = 0;
    while (!req_ready && c < 1000) begin @(negedge clk); c++; end
    hs = 1; c = 0; t_rsp1 = -1; t_hs2 = -1; t_rsp2 = -1; drop = 0;
    while (c < 2000 && t_rsp2 < 0) begin
      @(negedge clk); c++;
      if (drop) begin req_valid = 1'b0; drop = 0; end
      if (rsp_valid) begin
        if (t_rsp1 < 0) t_rsp1 = c; else t_rsp2 = c;
      end
      if (req_valid && req_ready) begin hs++; t_hs2 = c; drop = 1; end
    end
    req_valid = 1'b0;
    chk("held_accept_count", 64'(hs), 64'd2);
    chk("held_accept_cycle", 64'(t_hs2), 64'(t_rsp1 + 1));
    chk("held_rsp_gap", 64'(t_rsp2 - t_rsp1), 64'(exp_lat(0) + 1));
    chk("held_rdata", 64'(rsp_rdata), 64'h1234);

    // Reset during frame bit 40
    b40 = 1 + 4 * (40 - (257 - exp_lat(0)) / 4) + 1;
    @(negedge clk);
    req_write = 1'b1; req_phy = 5'd1; req_reg = 5'd5; req_wdata = 16'hBEEF; req_valid = 1'b1;
    c = 0;
    while (!req_ready && c < 1000) begin @(negedge clk); c++; end
    @(negedge clk); req_valid = 1'b0; lat = 1;
    while (lat < b40) begin @(negedge clk); lat++; end
    chk("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_outputs", {req_ready, rsp_valid, rsp_rdata, busy, mdc, mdio_o, mdio_oe},
        {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0});
    @(negedge clk); rst = 1'b0;
    nrsp = 0;
    repeat (300) begin @(negedge clk); if (rsp_valid) nrsp++; end
    chk("abort_no_rsp", 64'(nrsp), 64'd0);
    send(1'b0, 5'd3, 5'd2, 16'h0, lat);
    chk("post_abort_latency", 64'(lat), 64'(exp_lat(1)));
    chk("post_abort_rdata", 64'(rsp_rdata), 64'h1234);
    chk("mdio_stable_at_rise", 64'(viol), 64'd0);

    // ClkDiv=20 instance: one write frame
    @(negedge clk); v20 = 1'b1;
    c = 0;
    while (!rdy20 && c < 100) begin @(negedge clk); c++; end
    @(negedge clk); v20 = 1'b0; lat = 1;
    while (!rsp20 && lat < 20000) begin @(negedge clk); lat++; end
    chk("div20_latency", 64'(lat), 64'd2561);
    chk("div20_periods", 64'(nper20), 64'd63);
    chk("div20_bad_period", 64'(bad20), 64'd0);
    chk("div20_mdio_at_rise", 64'(viol20), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
